pcg: RTL and testbench
======================

# pcg

Program Counter Generator: the fetch-pipeline stage directly upstream of the instruction fetch unit. It holds the architectural fetch PC and streams one PC per accepted beat over AXI-Stream to the IFU's `pcgif` slave port. It takes backend redirects (branch mispredict, trap, `mret`) and drives the `invalidate` flush that clears the fetch pipeline. It optionally predicts taken branches with a small direct-mapped BTB.

## Interface
Parameters:
- `RESET_VECTOR`, default 0: first PC fetched after reset.
- `BTB_ENTRIES`, default 16: BTB entry count. Power of two, ≥2. Used only when `PCG_BTB_EN` is defined.

Ports:
- `clk`  input  1  clock.
- `rst`  input  1  reset; synchronous, active-high.
- `pcgif_axis_if`  axis_if.m  `$bits(pcgif_tdata_t)`  PC stream to the IFU.
  - `tdata` is `pcgif_tdata_t`.
  - Fields driven: `pc` (XLEN) and `pred_taken` (1).
  - All other fields are driven to 0.
- `redirect_valid`  input  1  backend redirect request.
- `redirect_pc`  input  XLEN  redirect target.
- `bu_valid`  input  1  BTB update strobe from execute.
- `bu_pc`  input  XLEN  PC of the resolved branch.
- `bu_target`  input  XLEN  resolved branch target.
- `bu_taken`  input  1  resolved branch direction.
- `invalidate`  output  1  flush pulse to the IFU and its pipe registers.

## Operation
- Registers:
  - `pc_q`: current fetch PC.
  - `state_q`: one of BOOT or RUN.
- `pcgif_axis_if.tdata.pc = pc_q`.
- `tvalid = (state_q == RUN) && !redirect_valid`.
- Next-PC selection, in priority order:
  1. `redirect_valid`: `pc_q <= {redirect_pc[XLEN-1:2], 2'b00}`. No C extension, so bits [1:0] are dropped.
  2. Handshake (`tvalid && tready`): `pc_q <= pred_hit ? pred_target : pc_q + 4`.
  3. Otherwise `pc_q` holds.
- `pc_q + 4` is modulo 2^XLEN; `32'hFFFF_FFFC` wraps to 0.
- `invalidate = redirect_valid`. It is combinational, same cycle, and held for as long as `redirect_valid` is high.
- Once asserted, tvalid and tdata are stable until the handshake completes. The only exception is `redirect_valid`, which withdraws the beat; this is legal because `invalidate` flushes the consumer in the same cycle.
- State machine:
  - Reset goes to BOOT.
  - BOOT → RUN unconditionally on the next cycle.
  - RUN stays in RUN.
  - A redirect in BOOT loads `pc_q` and still moves to RUN.
- BTB (with `PCG_BTB_EN` only):
  - Index bits: `pc[2 +: $clog2(BTB_ENTRIES)]`.
  - Tag: the remaining upper bits.
  - Entry contents: {valid, tag, target, taken}.
  - Lookup on `pc_q` is combinational: `pred_hit = valid && tag match && taken`, and `pred_taken = pred_hit`.
  - `bu_valid` writes the entry indexed by `bu_pc` with valid=1, `bu_pc`'s tag, `bu_target` and `bu_taken`.
  - An update and a lookup of the same entry in the same cycle: the lookup sees the old contents.
  - `bu_valid` together with `redirect_valid` is legal; both take effect.

## Timing
- Reset values:
  - `pc_q = RESET_VECTOR`, `state_q = BOOT`.
  - `tvalid = 0`, `invalidate = 0` (while `redirect_valid` = 0).
  - All BTB valid bits = 0; targets and tags are not reset.
- First beat: tvalid=1 with `pc = RESET_VECTOR` on the first cycle after `rst` deasserts.
- Throughput: one PC per cycle while `tready` = 1.
- Redirect latency:
  - Redirect in cycle N: `invalidate` = 1 and `tvalid` = 0 in cycle N.
  - The new PC is presented with `tvalid` = 1 in cycle N+1.
- Back-to-back redirects: the last one wins; `tvalid` stays 0 until the cycle after the final redirect.
- BTB update in cycle N is visible to lookups from cycle N+1.
- `rst` asserted mid-stream: the next cycle is in the reset state. An in-flight beat is dropped without any handshake.

## Configuration
- `PCG_BTB_EN` defined:
  - The BTB is instantiated.
  - `pred_taken` and the next-PC target follow the BTB.
- `PCG_BTB_EN` not defined:
  - No BTB storage.
  - The next PC is always `pc_q + 4`; `pred_taken` = 0.
  - `bu_*` inputs are ignored; `BTB_ENTRIES` is unused.

## Test plan
- **Reset and stream:** `RESET_VECTOR=32'h8000_0000`, `tready` = 1, release `rst` → beats 0x8000_0000, 0x8000_0004, 0x8000_0008 in consecutive cycles; `invalidate` = 0.
- **Backpressure:** `tready` = 0 for 3 cycles while a beat is pending → `pc` held at 0x8000_0004 with `tvalid` = 1. After `tready` = 1, the next beat is 0x8000_0008.
- **Redirect:** `redirect_valid` = 1 with `redirect_pc = 32'h0000_1003` during a stalled beat → `invalidate` = 1 and `tvalid` = 0 that cycle; the next cycle presents `pc = 0x0000_1000`.
- **Wrap:** redirect to 0xFFFF_FFFC, then accept 2 beats → 0xFFFF_FFFC, then 0x0000_0000.
- **BTB (`PCG_BTB_EN`):** `bu_valid` with `bu_pc=0x100`, `bu_target=0x200`, `bu_taken=1`; then redirect to 0x100 → beat 0x100 with `pred_taken` = 1, next beat 0x200. Updating the same entry with `bu_taken=0` makes the beat after 0x100 be 0x104.
- **Simultaneous events:** `bu_valid` and `redirect_valid` in the same cycle as a handshake → the redirect target wins, the BTB entry is written, and no extra beat is emitted.

Source files
------------

// File: rtl/pcg_if.sv
// AXI-Stream carrying fetch PCs from the PC generator to the IFU.
// tdata is pcgif_tdata_t: pc in [31:0], pred_taken in [32], reserved bits above.
interface axis_if;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [30:0]     rsvd;
    logic            pred_taken;
    logic [XLEN-1:0] pc;
  } pcgif_tdata_t;

  logic         tvalid;
  logic         tready;
  pcgif_tdata_t tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/pcg.sv
// Program Counter Generator: holds the fetch PC, streams one PC per accepted beat,
// takes backend redirects and flushes the fetch pipe via invalidate.
// Optional direct-mapped BTB enabled by defining PCG_BTB_EN.
module pcg #(
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int unsigned BTB_ENTRIES  = 16
) (
  input  logic        clk,
  input  logic        rst,
  axis_if.m           pcgif_axis_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        bu_valid,
  input  logic [31:0] bu_pc,
  input  logic [31:0] bu_target,
  input  logic        bu_taken,
  output logic        invalidate
);
  localparam int unsigned XLEN = 32;

  typedef enum logic {StBoot, StRun} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              tvalid;
  logic              handshake;
  logic              pred_hit;
  logic [XLEN-1:0]   pred_target;

`ifdef PCG_BTB_EN
  localparam int unsigned IdxW = $clog2(BTB_ENTRIES);
  localparam int unsigned TagW = XLEN - 2 - IdxW;

  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [BTB_ENTRIES-1:0] btb_taken_q;
  logic [TagW-1:0]        btb_tag_q [BTB_ENTRIES];
  logic [XLEN-3:0]        btb_tgt_q [BTB_ENTRIES];
  logic [IdxW-1:0]        rd_idx, wr_idx;
  logic                   unused_btb_lo;

  assign rd_idx = pc_q[2 +: IdxW];
  assign wr_idx = bu_pc[2 +: IdxW];
  // Low address bits carry no information without the C extension.
  assign unused_btb_lo = ^{bu_pc[1:0], bu_target[1:0]};

  // Valid bits are the only reset BTB state.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid_q <= '0;
    end else if (bu_valid) begin
      btb_valid_q[wr_idx] <= 1'b1;
    end
  end

  // Entry payload write; not reset.
  always_ff @(posedge clk) begin
    if (bu_valid) begin
      btb_tag_q[wr_idx]   <= bu_pc[XLEN-1 -: TagW];
      btb_tgt_q[wr_idx]   <= bu_target[XLEN-1:2];
      btb_taken_q[wr_idx] <= bu_taken;
    end
  end

  // Lookup reads registered contents, so a same-cycle update is seen next cycle.
  always_comb begin
    pred_hit    = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == pc_q[XLEN-1 -: TagW]) &&
                  btb_taken_q[rd_idx];
    pred_target = {btb_tgt_q[rd_idx], 2'b00};
  end
`else
  localparam int unsigned unused_btb_entries = BTB_ENTRIES;
  logic unused_bu;

  assign unused_bu = ^{bu_valid, bu_pc, bu_target, bu_taken};

  // Without a BTB every beat falls through to pc + 4.
  always_comb begin
    pred_hit    = 1'b0;
    pred_target = '0;
  end
`endif

  // A redirect withdraws the beat; invalidate flushes the consumer that cycle.
  assign tvalid     = (state_q == StRun) && !redirect_valid;
  assign handshake  = tvalid && pcgif_axis_if.tready;
  assign invalidate = redirect_valid;

  assign pcgif_axis_if.tvalid = tvalid;
  assign pcgif_axis_if.tdata  = {31'd0, pred_hit, pc_q};

  // Next-state and next-PC selection: redirect, then handshake, else hold.
  always_comb begin
    state_d = StRun;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (handshake) begin
      pc_d = pred_hit ? pred_target : pc_q + 32'd4;
    end
  end

  // State and PC registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
endmodule

// File: tb/tb_pcg.sv
// Directed bench for pcg with RESET_VECTOR = 0x8000_0000.
// BTB expectations depend on whether PCG_BTB_EN is defined.
module tb_pcg;
`ifdef PCG_BTB_EN
  localparam bit BtbEn = 1'b1;
`else
  localparam bit BtbEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bu_valid;
  logic [31:0] bu_pc;
  logic [31:0] bu_target;
  logic        bu_taken;
  logic        invalidate;

  int n_checks = 0;
  int n_pass   = 0;

  axis_if pcgif ();

  pcg #(
    .RESET_VECTOR(32'h8000_0000),
    .BTB_ENTRIES (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pcgif_axis_if (pcgif),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .bu_valid      (bu_valid),
    .bu_pc         (bu_pc),
    .bu_target     (bu_target),
    .bu_taken      (bu_taken),
    .invalidate    (invalidate)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check a presented beat: tvalid, pc, invalidate.
  task automatic beat(input string tag, input logic [31:0] exp_pc);
    check({tag, "_tvalid"}, 32'(pcgif.tvalid), 32'd1);
    check({tag, "_pc"}, pcgif.tdata[31:0], exp_pc);
    check({tag, "_inv"}, 32'(invalidate), 32'd0);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    #1;
    check("redir_inv", 32'(invalidate), 32'd1);
    check("redir_tvalid", 32'(pcgif.tvalid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; pcgif.tready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    bu_valid = 1'b0; bu_pc = '0; bu_target = '0; bu_taken = 1'b0;
    tick(); tick();
    check("rst_tvalid", 32'(pcgif.tvalid), 32'd0);
    check("rst_inv", 32'(invalidate), 32'd0);
    check("rst_pc", pcgif.tdata[31:0], 32'h8000_0000);

    // Reset and stream.
    rst = 1'b0; #1;
    check("boot_tvalid", 32'(pcgif.tvalid), 32'd0);
    tick(); beat("s0", 32'h8000_0000);
    tick(); beat("s1", 32'h8000_0004);
    tick(); beat("s2", 32'h8000_0008);

    // Mid-stream reset drops the pending beat.
    rst = 1'b1; tick();
    check("mrst_tvalid", 32'(pcgif.tvalid), 32'd0);
    check("mrst_pc", pcgif.tdata[31:0], 32'h8000_0000);
    rst = 1'b0; tick(); beat("r0", 32'h8000_0000);

    // Backpressure on the second beat.
    tick();
    pcgif.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; beat("bp", 32'h8000_0004);
      tick();
    end
    beat("bp_end", 32'h8000_0004);
    pcgif.tready = 1'b1; tick();
    beat("bp_next", 32'h8000_0008);

    // Redirect during a stalled beat; low bits dropped.
    pcgif.tready = 1'b0;
    redirect(32'h0000_1003);
    beat("rd", 32'h0000_1000);
    pcgif.tready = 1'b1; tick();
    beat("rd_next", 32'h0000_1004);

    // Back-to-back redirects: last one wins.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000; tick();
    redirect_pc = 32'h0000_3000; #1;
    check("b2b_tvalid", 32'(pcgif.tvalid), 32'd0);
    tick(); redirect_valid = 1'b0; #1;
    beat("b2b", 32'h0000_3000);

    // Wrap at the top of the address space.
    redirect(32'hFFFF_FFFC);
    beat("wrap0", 32'hFFFF_FFFC);
    tick(); beat("wrap1", 32'h0000_0000);

    // BTB training then redirect onto the trained branch.
    bu_valid = 1'b1; bu_pc = 32'h100; bu_target = 32'h200; bu_taken = 1'b1;
    tick(); bu_valid = 1'b0;
    redirect(32'h100);
    beat("btb_hit", 32'h100);
    check("btb_pred", 32'(pcgif.tdata[32]), BtbEn ? 32'd1 : 32'd0);
    tick(); beat("btb_tgt", BtbEn ? 32'h200 : 32'h104);
    check("btb_tgt_pred", 32'(pcgif.tdata[32]), 32'd0);

    // Retrain as not-taken.
    bu_valid = 1'b1; bu_taken = 1'b0;
    tick(); bu_valid = 1'b0;
    redirect(32'h100);
    check("btb_nt_pred", 32'(pcgif.tdata[32]), 32'd0);
    tick(); beat("btb_nt", 32'h104);

    // Redirect, BTB update and a ready consumer in the same cycle.
    bu_valid = 1'b1; bu_pc = 32'h500; bu_target = 32'h900; bu_taken = 1'b1;
    redirect(32'h500);
    bu_valid = 1'b0;
    beat("sim", 32'h500);
    check("sim_pred", 32'(pcgif.tdata[32]), BtbEn ? 32'd1 : 32'd0);
    tick(); beat("sim_next", BtbEn ? 32'h900 : 32'h504);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
